// File: rtl/am_pwm_scheduler.sv
// rtl/am_pwm_scheduler.sv - PWM sample scheduler: paces upstream samples into per-period duty loads.
// One-entry sample buffer, step/PWM-step/period counters and a 4-state run FSM.
module am_pwm_scheduler #(
  parameter int PWM_STEPS          = 64,
  parameter int CLKS_IN_PWM_STEP   = 4,
  parameter int PERIODS_PER_SAMPLE = 1,
  parameter int DUTY_W             = 8,
  parameter int IDLE_DUTY          = PWM_STEPS / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              step_tick,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_load,
  output logic              underflow,
  input  logic              underflow_clr,
  output logic              busy
);

  localparam int SW = (CLKS_IN_PWM_STEP > 1) ? $clog2(CLKS_IN_PWM_STEP) : 1;
  localparam int PW = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int QW = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(CLKS_IN_PWM_STEP - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_STEPS - 1);
  localparam logic [QW-1:0] PER_LAST  = QW'(PERIODS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_UNDERFLOW} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     step_cnt;
  logic [PW-1:0]     pwm_cnt;
  logic [QW-1:0]     per_cnt;
  logic [DUTY_W-1:0] next_data;
  logic              next_valid;
  logic              draining;

  logic              running, period_end, sample_end, stopping, accept;
  logic              load_en, consume, bypass, prime_start, set_uf;
  logic [DUTY_W-1:0] load_val;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v);
    return (v > DUTY_W'(PWM_STEPS)) ? DUTY_W'(PWM_STEPS) : v;
  endfunction

  assign busy    = (state != S_IDLE);
  assign s_ready = (state != S_IDLE) && !next_valid;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    running     = (state == S_RUN) || (state == S_UNDERFLOW);
    step_tick   = running && (step_cnt == STEP_LAST);
    period_end  = step_tick && (pwm_cnt == PWM_LAST);
    sample_end  = period_end && (per_cnt == PER_LAST);
    stopping    = draining || !enable;
    state_nx    = state;
    load_en     = 1'b0;
    load_val    = duty;
    consume     = 1'b0;
    bypass      = 1'b0;
    prime_start = 1'b0;
    set_uf      = 1'b0;
    case (state)
      S_IDLE: if (enable) state_nx = S_PRIME;
      S_PRIME: begin
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (next_valid || accept) begin
          // A sample arriving while priming goes straight to duty, skipping the buffer.
          state_nx    = S_RUN;
          load_en     = 1'b1;
          load_val    = clamp_duty(next_valid ? next_data : s_data);
          consume     = next_valid;
          bypass      = !next_valid;
          prime_start = 1'b1;
        end
      end
      S_RUN, S_UNDERFLOW: begin
        if (period_end && stopping) begin
          state_nx = S_IDLE;
          load_en  = 1'b1;
          load_val = '0;
        end else if (sample_end) begin
          load_en = 1'b1;
          if (next_valid) begin
            state_nx = S_RUN;
            load_val = clamp_duty(next_data);
            consume  = 1'b1;
          end else begin
            state_nx = S_UNDERFLOW;
            load_val = DUTY_W'(IDLE_DUTY);
            set_uf   = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt     <= '0;
      pwm_cnt      <= '0;
      per_cnt      <= '0;
      next_data    <= '0;
      next_valid   <= 1'b0;
      draining     <= 1'b0;
      duty         <= '0;
      duty_load    <= 1'b0;
      period_start <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (running && state_nx != S_IDLE) begin
        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
        if (step_tick)  pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        if (period_end) per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
      end else begin
        step_cnt <= '0;
        pwm_cnt  <= '0;
        per_cnt  <= '0;
      end

      // Once a stop is requested it sticks until IDLE, even if enable returns.
      draining <= running && (state_nx != S_IDLE) && (draining || !enable);

      if (consume) begin
        next_valid <= 1'b0;
      end else if (accept && !bypass) begin
        next_valid <= 1'b1;
        next_data  <= s_data;
      end

      if (load_en) duty <= load_val;
      duty_load    <= load_en;
      period_start <= period_end || prime_start;

      if (set_uf)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_am_pwm_scheduler.sv
// tb/tb_am_pwm_scheduler.sv - self-checking bench for am_pwm_scheduler (8 steps x 2 clks).
`timescale 1ns/1ps
module tb_am_pwm_scheduler;

  localparam int STEPS  = 8;
  localparam int CLKS   = 2;
  localparam int PPS    = 1;
  localparam int DW     = 8;
  localparam int IDLE_D = STEPS / 2;
  localparam int PER    = STEPS * CLKS;

  logic          clk = 1'b0;
  logic          rst, enable, s_valid, underflow_clr;
  logic [DW-1:0] s_data;
  logic          s_ready, step_tick, period_start, duty_load, underflow, busy;
  logic [DW-1:0] duty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am_pwm_scheduler #(
    .PWM_STEPS(STEPS), .CLKS_IN_PWM_STEP(CLKS), .PERIODS_PER_SAMPLE(PPS),
    .DUTY_W(DW), .IDLE_DUTY(IDLE_D)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .step_tick(step_tick), .period_start(period_start),
    .duty(duty), .duty_load(duty_load), .underflow(underflow),
    .underflow_clr(underflow_clr), .busy(busy)
  );

  // Output word: {s_ready, step_tick, period_start, duty_load, underflow, busy, duty}
  function automatic logic [13:0] pack(input bit rdy, st, ps, dl, uf, bz, input int d);
    return {rdy, st, ps, dl, uf, bz, 8'(d)};
  endfunction

  function automatic logic [13:0] obs();
    return {s_ready, step_tick, period_start, duty_load, underflow, busy, duty};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks position in the period as a plain cycle count.
  int  m_mode;  // 0 off, 1 waiting for first sample, 2 playing samples, 3 playing idle duty
  int  m_t, m_per, m_duty;
  bit  m_stop, m_dl, m_ps, m_uf;
  int  m_q[$];

  function automatic int clampd(input int v);
    return (v > STEPS) ? STEPS : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_per = 0; m_duty = 0;
    m_stop = 0; m_dl = 0; m_ps = 0; m_uf = 0;
    m_q.delete();
  endtask

  function automatic logic [13:0] model_exp();
    return pack((m_mode != 0) && (m_q.size() == 0),
                (m_mode >= 2) && (m_t % CLKS == CLKS - 1),
                m_ps, m_dl, m_uf, m_mode != 0, m_duty);
  endfunction

  task automatic model_edge(input bit en, input bit sv, input int sd, input bit clr);
    bit accept;
    bit set_uf;
    accept = (m_mode != 0) && (m_q.size() == 0) && sv;
    set_uf = 0;
    m_dl = 0;
    m_ps = 0;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 0;
        else if (m_q.size() > 0 || accept) begin
          if (m_q.size() > 0) m_duty = clampd(m_q.pop_front());
          else begin m_duty = clampd(sd); accept = 0; end
          m_dl = 1; m_ps = 1; m_t = 0; m_per = 0; m_mode = 2;
        end
      end
      default: begin
        if (!en) m_stop = 1;
        if (m_t == PER - 1) begin
          m_ps = 1;
          m_t  = 0;
          if (m_stop) begin
            m_duty = 0; m_dl = 1; m_mode = 0; m_stop = 0; m_per = 0;
          end else if (m_per == PPS - 1) begin
            m_per = 0;
            m_dl  = 1;
            if (m_q.size() > 0) begin m_duty = clampd(m_q.pop_front()); m_mode = 2; end
            else begin m_duty = IDLE_D; set_uf = 1; m_mode = 3; end
          end else begin
            m_per++;
          end
        end else begin
          m_t++;
        end
      end
    endcase
    if (accept) m_q.push_back(sd);
    if (set_uf) m_uf = 1;
    else if (clr) m_uf = 0;
  endtask

  typedef struct {
    bit            rst, en, sv, clr;
    logic [DW-1:0] sd;
    logic [13:0]   exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, e, v, c, input int d, input logic [13:0] x);
    vec_t row;
    row.rst = r; row.en = e; row.sv = v; row.clr = c; row.sd = 8'(d); row.exp = x;
    tbl.push_back(row);
  endtask

  int  dv[5] = '{1, 2, 3, 4, 5};
  bit  r_sv, r_rdy, r_uf, r_clr;
  int  r_sd, n, ticks, stray;

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; underflow_clr = 1'b0;

    // Start, streaming 1,2,3, underflow to 4, refill with 5, underflow_clr.
    add(1, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, 1, pack(1, 0, 0, 0, 0, 1, 0));
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < PER; t++) begin
        r_sv  = (p == 0) || ((p == 1 || p == 3) && t == 0);
        r_sd  = (p == 0) ? ((t == 0) ? 2 : 3) : ((p == 1) ? 3 : 5);
        r_rdy = (p == 2 || p == 4) ? 1'b1 : (t == 0);
        r_uf  = (p == 3) || (p == 4 && t <= 3);
        r_clr = (p == 4 && t == 3);
        add(0, 1, r_sv, r_clr, r_sd,
            pack(r_rdy, t % CLKS == CLKS - 1, t == 0, t == 0, r_uf, 1, dv[p]));
      end
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; s_valid = tbl[i].sv;
      s_data = tbl[i].sd; underflow_clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
      to_drive();
    end
    underflow_clr = 1'b0;

    // Second underflow, then an over-range sample is clamped at the next boundary.
    s_valid = 1'b1; s_data = 8'd200;
    @(negedge clk);
    chk("underflow_reentry", 32'(obs()), 32'(pack(1, 0, 1, 1, 1, 1, IDLE_D)));
    n = 0;
    do begin
      to_drive();
      s_valid = 1'b0;
      @(negedge clk);
      n++;
    end while (!duty_load && n < 40);
    chk("clamp_latency", n, PER);
    chk("clamp_duty", duty, STEPS);
    chk("clamp_uf_kept", underflow, 1);

    // Disable 5 clks into a period; enable bounces back mid-drain; a sample arrives.
    ticks = 0;
    for (int t = 1; t < PER; t++) begin
      to_drive();
      if (t == 5)  enable = 1'b0;
      if (t == 10) enable = 1'b1;
      s_valid = (t == 6);
      s_data  = 8'd6;
      @(negedge clk);
      if (t >= 5) ticks += int'(step_tick);
    end
    chk("drain_ticks", ticks, 6);
    chk("drain_last", 32'(obs()), 32'(pack(0, 1, 0, 0, 1, 1, STEPS)));
    to_drive();
    s_valid = 1'b0;
    @(negedge clk);
    chk("drain_done", 32'(obs()), 32'(pack(0, 0, 1, 1, 1, 0, 0)));
    to_drive();
    @(negedge clk);
    chk("reprime_pending", 32'(obs()), 32'(pack(0, 0, 0, 0, 1, 1, 0)));
    to_drive();
    @(negedge clk);
    chk("pending_used", 32'(obs()), 32'(pack(1, 0, 1, 1, 1, 1, 6)));

    // Reset mid-run with a buffered sample: everything clears, sample is dropped.
    to_drive();
    s_valid = 1'b1; s_data = 8'd2;
    to_drive();
    s_valid = 1'b0;
    #2;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("rst_async", 32'(obs()), 32'(0));
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", 32'(obs()), 32'(0));
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      to_drive();
      @(negedge clk);
      stray += int'(duty_load) + int'(busy) + int'(s_ready) + int'(step_tick);
    end
    chk("rst_quiet", stray, 0);
    to_drive();
    enable = 1'b1;
    to_drive();
    @(negedge clk);
    chk("rst_discard", 32'(obs()), 32'(pack(1, 0, 0, 0, 0, 1, 0)));

    // Randomized run against the reference model, including random resets.
    to_drive();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("random_cycle", 32'(obs()), 32'(model_exp()));
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(enable, s_valid, int'(s_data), underflow_clr);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      underflow_clr = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
